// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one multi-cycle ALU between two requesters.
// Each accepted operation is issued for ALU_LAT cycles and answered on a valid/ready port.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [3:0]  req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [3:0]  req1_cmd,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_en,
  input  logic [15:0] alu_out,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  input  logic        rsp_ready
);

  localparam logic [3:0] CMD_DIV  = 4'b0101;
  localparam logic [1:0] CNT_LOAD = 2'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state;
  logic       last_grant;
  logic [1:0] count;
  logic       grant_any;
  logic       grant_id;
  logic       accept;
  logic       div_zero;

  // On contention the requester that did not win the previous accept goes next.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
  end

  assign req0_ready = (state == IDLE) && grant_any && !grant_id;
  assign req1_ready = (state == IDLE) && grant_any && grant_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign div_zero   = (alu_cmd == CMD_DIV) && (alu_b == 8'h00);

  // last_grant doubles as the index of the operation in flight, so rsp_id comes from it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= 2'd0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_cmd    <= 4'h0;
      alu_en     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= grant_id ? req1_a   : req0_a;
            alu_b      <= grant_id ? req1_b   : req0_b;
            alu_cmd    <= grant_id ? req1_cmd : req0_cmd;
            last_grant <= grant_id;
            count      <= CNT_LOAD;
            alu_en     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (count == 2'd0) begin
            alu_en    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= last_grant;
            rsp_err   <= div_zero;
            rsp_data  <= div_zero ? 16'h0000 : alu_out;
            state     <= RESP;
          end else begin
            count <= count - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_arbiter: one instance with ALU_LAT=1 for the main scenarios,
// a second with ALU_LAT=3 for the long-latency case, each fed by a behavioural ALU.
module tb_alu_arbiter;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_INC = 4'b0011;
  localparam logic [3:0] CMD_DIV = 4'b0101;

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic        err;
    int          acc_cyc;
  } exp_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
  logic [7:0]  req0_a = 8'h0, req0_b = 8'h0, req1_a = 8'h0, req1_b = 8'h0;
  logic [3:0]  req0_cmd = 4'h0, req1_cmd = 4'h0;
  logic [15:0] req0_exp = 16'h0, req1_exp = 16'h0;
  logic        req0_exp_err = 1'b0, req1_exp_err = 1'b0;
  logic        req0_ready, req1_ready, alu_en, rsp_valid, rsp_id, rsp_err;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_cmd;
  logic [15:0] alu_out, rsp_data;
  exp_t        sb[$];
  logic        grant_log[$];
  int          n_acc = 0, en_cyc = 0, en_run = 0;
  logic        prev_valid = 1'b0;
  exp_t        e;

  logic        l3_valid = 1'b0, l3_rsp_ready = 1'b1;
  logic [7:0]  l3_a = 8'h0, l3_b = 8'h0;
  logic [3:0]  l3_cmd = 4'h0;
  logic [15:0] l3_exp = 16'h0;
  logic        l3_ready, l3_ready1, l3_en, l3_rsp_valid, l3_rsp_id, l3_rsp_err;
  logic [7:0]  l3_alu_a, l3_alu_b;
  logic [3:0]  l3_alu_cmd;
  logic [15:0] l3_alu_out, l3_rsp_data;
  exp_t        sb3[$];
  int          n_acc3 = 0, en_cyc3 = 0, en_run3 = 0;
  logic        prev_valid3 = 1'b0;
  exp_t        e3;

  alu_arbiter #(.ALU_LAT(1)) u_dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_en(alu_en), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  alu_arbiter #(.ALU_LAT(3)) u_dut3 (
    .clock(clock), .resetn(resetn),
    .req0_valid(l3_valid), .req0_ready(l3_ready), .req0_a(l3_a), .req0_b(l3_b), .req0_cmd(l3_cmd),
    .req1_valid(1'b0), .req1_ready(l3_ready1), .req1_a(8'h00), .req1_b(8'h00), .req1_cmd(4'h0),
    .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_cmd(l3_alu_cmd), .alu_en(l3_en), .alu_out(l3_alu_out),
    .rsp_valid(l3_rsp_valid), .rsp_id(l3_rsp_id), .rsp_err(l3_rsp_err), .rsp_data(l3_rsp_data),
    .rsp_ready(l3_rsp_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: return 16'(a) + 16'(b);
      CMD_INC: return 16'(a) + 16'd1;
      CMD_DIV: return (b == 8'h00) ? 16'hDEAD : 16'(a / b);
      default: return {8'h00, a};
    endcase
  endfunction

  // The ALU result is only meaningful in the last enabled cycle; otherwise it shows garbage.
  always @(posedge clock) en_cyc  <= alu_en ? en_cyc + 1 : 0;
  always @(posedge clock) en_cyc3 <= l3_en ? en_cyc3 + 1 : 0;
  always_comb alu_out    = (alu_en && en_cyc == 0) ? alu_ref(alu_a, alu_b, alu_cmd) : 16'hBAD0;
  always_comb l3_alu_out = (l3_en && en_cyc3 == 2) ? alu_ref(l3_alu_a, l3_alu_b, l3_alu_cmd) : 16'hBAD0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue side: the hand-computed expectation of whichever requester is accepted gets queued.
  always @(negedge clock) begin
    if (resetn && req0_valid && req0_ready) begin
      sb.push_back('{1'b0, req0_exp, req0_exp_err, cyc + 1});
      grant_log.push_back(1'b0);
      n_acc++;
    end
    if (resetn && req1_valid && req1_ready) begin
      sb.push_back('{1'b1, req1_exp, req1_exp_err, cyc + 1});
      grant_log.push_back(1'b1);
      n_acc++;
    end
    if (resetn && l3_valid && l3_ready) begin
      sb3.push_back('{1'b0, l3_exp, 1'b0, cyc + 1});
      n_acc3++;
    end
  end

  always @(negedge clock) begin
    if (!resetn) begin
      en_run     = 0;
      prev_valid = 1'b0;
    end else begin
      check_output("both_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (alu_en) en_run++;
      if (rsp_valid && !prev_valid && sb.size() != 0) begin
        check_output("latency", cyc - sb[0].acc_cyc + 1, 32'd2);
        check_output("alu_en_cycles", en_run, 32'd1);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check_output("spurious_rsp", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check_output("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
          check_output("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
          check_output("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        end
        en_run = 0;
      end
      prev_valid = rsp_valid;
    end
  end

  always @(negedge clock) begin
    if (!resetn) begin
      en_run3     = 0;
      prev_valid3 = 1'b0;
    end else begin
      if (l3_en) en_run3++;
      if (l3_rsp_valid && !prev_valid3 && sb3.size() != 0) begin
        check_output("l3_latency", cyc - sb3[0].acc_cyc + 1, 32'd4);
        check_output("l3_alu_en_cycles", en_run3, 32'd3);
      end
      if (l3_rsp_valid && l3_rsp_ready) begin
        if (sb3.size() == 0) check_output("l3_spurious_rsp", 32'd1, 32'd0);
        else begin
          e3 = sb3.pop_front();
          check_output("l3_rsp_id", {31'b0, l3_rsp_id}, {31'b0, e3.id});
          check_output("l3_rsp_data", {16'b0, l3_rsp_data}, {16'b0, e3.data});
          check_output("l3_rsp_err", {31'b0, l3_rsp_err}, {31'b0, e3.err});
        end
        en_run3 = 0;
      end
      prev_valid3 = l3_rsp_valid;
    end
  end

  task automatic wait_accept(input bit use_l3, input int target);
    int i = 0;
    while ((use_l3 ? n_acc3 : n_acc) < target && i < 50) begin
      @(negedge clock); #1;
      i++;
    end
    if ((use_l3 ? n_acc3 : n_acc) < target) check_output("accept_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((sb.size() != 0 || rsp_valid || sb3.size() != 0 || l3_rsp_valid) && i < 50) begin
      @(negedge clock); #1;
      i++;
    end
    if (i >= 50) check_output("idle_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic apply_stimulus(input logic id, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] cmd, input logic [15:0] exp_data, input logic exp_err);
    if (id) begin
      req1_a = a; req1_b = b; req1_cmd = cmd; req1_exp = exp_data; req1_exp_err = exp_err;
      req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cmd = cmd; req0_exp = exp_data; req0_exp_err = exp_err;
      req0_valid = 1'b1;
    end
    wait_accept(1'b0, n_acc + 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int i;
    int base;
    logic [3:0] exp_g;
    repeat (3) @(posedge clock);
    #1;
    check_output("rst_alu_a", {24'b0, alu_a}, 32'd0);
    check_output("rst_alu_b", {24'b0, alu_b}, 32'd0);
    check_output("rst_alu_cmd", {28'b0, alu_cmd}, 32'd0);
    check_output("rst_alu_en", {31'b0, alu_en}, 32'd0);
    check_output("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_output("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
    check_output("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
    check_output("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    $display("[TB] single ADD on req0");
    apply_stimulus(1'b0, 8'd25, 8'd17, CMD_ADD, 16'd42, 1'b0);
    wait_idle();
    check_output("held_alu_a", {24'b0, alu_a}, 32'd25);
    check_output("held_alu_b", {24'b0, alu_b}, 32'd17);
    check_output("held_alu_cmd", {28'b0, alu_cmd}, {28'b0, CMD_ADD});

    $display("[TB] divide by zero on req1");
    apply_stimulus(1'b1, 8'd20, 8'd0, CMD_DIV, 16'h0000, 1'b1);
    wait_idle();

    $display("[TB] backpressure with both requesters waiting");
    rsp_ready = 1'b0;
    req0_a = 8'd100; req0_b = 8'd3;   req0_cmd = CMD_DIV; req0_exp = 16'd33;  req0_exp_err = 1'b0;
    req1_a = 8'd200; req1_b = 8'd100; req1_cmd = CMD_ADD; req1_exp = 16'd300; req1_exp_err = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_accept(1'b0, n_acc + 1);
    req0_valid = 1'b0;
    if (grant_log.size() != 0) check_output("bp_first_grant", {31'b0, grant_log[grant_log.size() - 1]}, 32'd0);
    i = 0;
    while (!rsp_valid && i < 20) begin
      @(negedge clock); #1;
      i++;
    end
    repeat (5) begin
      check_output("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check_output("bp_rsp_data", {16'b0, rsp_data}, 32'd33);
      check_output("bp_req1_ready", {31'b0, req1_ready}, 32'd0);
      @(negedge clock); #1;
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    wait_accept(1'b0, n_acc + 1);
    req1_valid = 1'b0;
    if (grant_log.size() != 0) check_output("bp_resume_grant", {31'b0, grant_log[grant_log.size() - 1]}, 32'd1);
    wait_idle();

    $display("[TB] ALU_LAT=3 increment");
    l3_a = 8'hFF; l3_b = 8'h00; l3_cmd = CMD_INC; l3_exp = 16'h0100;
    l3_valid = 1'b1;
    wait_accept(1'b1, n_acc3 + 1);
    l3_valid = 1'b0;
    wait_idle();

    $display("[TB] reset during ISSUE");
    apply_stimulus(1'b0, 8'd50, 8'd5, CMD_ADD, 16'd55, 1'b0);
    check_output("mid_issue_alu_en", {31'b0, alu_en}, 32'd1);
    resetn = 1'b0;
    sb.delete();
    #1;
    check_output("rst_async_alu_en", {31'b0, alu_en}, 32'd0);
    check_output("rst_async_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (4) begin
      @(negedge clock); #1;
      check_output("no_rsp_after_rst", {31'b0, rsp_valid}, 32'd0);
    end
    @(posedge clock); #1;

    $display("[TB] continuous contention");
    req0_a = 8'd3; req0_b = 8'd4; req0_cmd = CMD_ADD; req0_exp = 16'd7;  req0_exp_err = 1'b0;
    req1_a = 8'd9; req1_b = 8'd0; req1_cmd = CMD_INC; req1_exp = 16'd10; req1_exp_err = 1'b0;
    base = grant_log.size();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_accept(1'b0, n_acc + 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    exp_g = 4'b1010;
    for (int k = 0; k < 4 && base + k < grant_log.size(); k++)
      check_output("contention_grant", {31'b0, grant_log[base + k]}, {31'b0, exp_g[k]});

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
